// File: rtl/regfile_32.sv
// =============================================================================
// Module   : regfile_32 (with local helper mux_32)
// Purpose  : 32 x WIDTH general-purpose register file, r0 hardwired to zero,
//            one write port, two combinational read ports.
// Options  : define REGFILE_WRITE_BYPASS_EN for same-cycle write-to-read bypass
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module mux_32 #(
  parameter int WIDTH = 32
) (
  input  logic [32*WIDTH-1:0] data_in,
  input  logic [4:0]          sel,
  output logic [WIDTH-1:0]    data_out
);
  assign data_out = data_in[sel*WIDTH +: WIDTH];
endmodule

module regfile_32 #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [DEPTH_LOG2-1:0] write_reg,
  input  logic [WIDTH-1:0]      write_data,
  input  logic [DEPTH_LOG2-1:0] read_reg_a,
  input  logic [DEPTH_LOG2-1:0] read_reg_b,
  output logic [WIDTH-1:0]      read_data_a,
  output logic [WIDTH-1:0]      read_data_b
);

  localparam int c_DEPTH = 32;

  if (DEPTH_LOG2 != 5) begin : g_bad_depth
    $error("regfile_32: DEPTH_LOG2 must be 5");
  end

  logic [c_DEPTH-1:1]         w_wr_sel;
  logic [c_DEPTH*WIDTH-1:0]   w_rd_bus;
  logic [WIDTH-1:0]           w_mux_a;
  logic [WIDTH-1:0]           w_mux_b;

  // Entry 0 has no storage; its slot on the read bus is tied low.
  assign w_rd_bus[WIDTH-1:0] = '0;

  for (genvar i = 1; i < c_DEPTH; i++) begin : g_reg
    logic [WIDTH-1:0] r_q;

    assign w_wr_sel[i] = write_enable && (write_reg == DEPTH_LOG2'(i));

    always_ff @(posedge clock or posedge reset) begin
      if (reset)
        r_q <= '0;
      else if (w_wr_sel[i])
        r_q <= write_data;
    end

    assign w_rd_bus[i*WIDTH +: WIDTH] = r_q;
  end

  mux_32 #(.WIDTH(WIDTH)) u_mux_a (
    .data_in  (w_rd_bus),
    .sel      (read_reg_a),
    .data_out (w_mux_a)
  );

  mux_32 #(.WIDTH(WIDTH)) u_mux_b (
    .data_in  (w_rd_bus),
    .sel      (read_reg_b),
    .data_out (w_mux_b)
  );

`ifdef REGFILE_WRITE_BYPASS_EN
  logic w_byp_ok;
  // Forward the writeback value so decode sees it in the same cycle.
  assign w_byp_ok    = write_enable && !reset && (write_reg != '0);
  assign read_data_a = (w_byp_ok && (read_reg_a == write_reg)) ? write_data : w_mux_a;
  assign read_data_b = (w_byp_ok && (read_reg_b == write_reg)) ? write_data : w_mux_b;
`else
  assign read_data_a = w_mux_a;
  assign read_data_b = w_mux_b;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_32.sv
// =============================================================================
// Module   : tb_regfile_32
// Purpose  : self-checking bench for regfile_32 against an array reference model.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_regfile_32;

  logic        clock = 1'b0;
  logic        reset;
  logic        write_enable;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg_a;
  logic [4:0]  read_reg_b;
  logic [31:0] read_data_a;
  logic [31:0] read_data_b;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] mdl [32];

  regfile_32 #(.WIDTH(32), .DEPTH_LOG2(5)) dut (
    .clock        (clock),
    .reset        (reset),
    .write_enable (write_enable),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .read_reg_a   (read_reg_a),
    .read_reg_b   (read_reg_b),
    .read_data_a  (read_data_a),
    .read_data_b  (read_data_b)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural view of what a read port should show right now.
  function automatic logic [31:0] exp_rd(input logic [4:0] idx);
    if (reset) return 32'h0;
    if (idx == 5'd0) return 32'h0;
`ifdef REGFILE_WRITE_BYPASS_EN
    if (write_enable && write_reg != 5'd0 && idx == write_reg) return write_data;
`endif
    return mdl[idx];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
  endtask

  task automatic set_reset(input logic v);
    reset = v;
    if (v) clear_model();
  endtask

  task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb);
    write_enable = we;
    write_reg    = wr;
    write_data   = wd;
    read_reg_a   = ra;
    read_reg_b   = rb;
  endtask

  task automatic tick();
    @(posedge clock);
    if (write_enable && !reset && write_reg != 5'd0) mdl[write_reg] = write_data;
    #1;
  endtask

  task automatic check_ports(input string tag);
    check({tag, "_a"}, read_data_a, exp_rd(read_reg_a));
    check({tag, "_b"}, read_data_b, exp_rd(read_reg_b));
  endtask

  task automatic wr_cycle(input logic [4:0] wr, input logic [31:0] wd);
    @(negedge clock);
    drive(1'b1, wr, wd, wr, 5'd0);
    tick();
    @(negedge clock);
    write_enable = 1'b0;
  endtask

  initial begin
    clear_model();
    set_reset(1'b1);
    drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd30);
    repeat (2) @(posedge clock);
    #1;
    check("reset_state_a", read_data_a, 32'h0);
    check("reset_state_b", read_data_b, 32'h0);
    @(negedge clock);
    set_reset(1'b0);

    // Async reset clears a loaded register before any clock edge.
    wr_cycle(5'd5, 32'hDEADBEEF);
    read_reg_a = 5'd5;
    #1;
    check("r5_loaded", read_data_a, 32'hDEADBEEF);
    #1;
    set_reset(1'b1);
    #1;
    check("r5_async_rst", read_data_a, 32'h0);
    @(negedge clock);
    set_reset(1'b0);

    // Basic write/read and all other entries untouched.
    wr_cycle(5'd7, 32'h12345678);
    wr_cycle(5'd31, 32'hFFFFFFFF);
    read_reg_a = 5'd7;
    read_reg_b = 5'd31;
    #1;
    check("r7", read_data_a, 32'h12345678);
    check("r31", read_data_b, 32'hFFFFFFFF);
    for (int i = 0; i < 32; i++) begin
      read_reg_a = 5'(i);
      #1;
      check("sweep", read_data_a, (i == 7) ? 32'h12345678 : (i == 31) ? 32'hFFFFFFFF : 32'h0);
    end

    // Zero register ignores writes.
    wr_cycle(5'd0, 32'hAAAAAAAA);
    read_reg_a = 5'd0;
    read_reg_b = 5'd0;
    #1;
    check("r0_a", read_data_a, 32'h0);
    check("r0_b", read_data_b, 32'h0);

    // Same-cycle read of the write target.
    wr_cycle(5'd3, 32'h11);
    drive(1'b1, 5'd3, 32'h22, 5'd3, 5'd3);
    #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    check("r3_same_cycle", read_data_a, 32'h22);
`else
    check("r3_same_cycle", read_data_a, 32'h11);
`endif
    tick();
    check("r3_after_edge", read_data_a, 32'h22);

    // Write disabled, both ports read the same index.
    @(negedge clock);
    drive(1'b0, 5'd9, 32'h55, 5'd9, 5'd9);
    tick();
    check("r9_we0_a", read_data_a, 32'h0);
    check("r9_we0_b", read_data_b, 32'h0);

    // Reset racing a write.
    @(negedge clock);
    drive(1'b1, 5'd12, 32'h77, 5'd12, 5'd3);
    set_reset(1'b1);
    tick();
    @(negedge clock);
    set_reset(1'b0);
    write_enable = 1'b0;
    #1;
    check("r12_rst_race", read_data_a, 32'h0);
    check("r3_rst_race", read_data_b, 32'h0);

    // Randomized traffic against the array model.
    for (int n = 0; n < 400; n++) begin
      @(negedge clock);
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom), $urandom, 5'($urandom), 5'($urandom));
      if ($urandom_range(0, 7) == 0) read_reg_a = write_reg;
      if ($urandom_range(0, 7) == 0) read_reg_b = write_reg;
      set_reset(1'($urandom_range(0, 39) == 0));
      #1;
      check_ports("rnd_pre");
      tick();
      check_ports("rnd_post");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_32.md
Name: regfile_32

Overview:
- 32-entry x 32-bit general-purpose register file: architectural state storage for the CPU.
- Sits directly upstream of the register-read muxes.
- Holds 32 registers; exposes all 32 register outputs to two mux_32 read trees (port A, port B) built inside this block.
- Accepts one write per cycle from the writeback stage; register 0 is hardwired to zero.

Parameters:
- WIDTH, 32, data width of each register and of the read/write data ports.
- DEPTH_LOG2, 5, register index width; fixed at 5 (32 entries). Other values are unsupported and must fail elaboration.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all registers.
- write_enable  input  1  commit write_data to write_reg on the next rising edge.
- write_reg  input  5  destination register index.
- write_data  input  WIDTH  value to write.
- read_reg_a  input  5  source index for port A.
- read_reg_b  input  5  source index for port B.
- read_data_a  output  WIDTH  contents of register read_reg_a.
- read_data_b  output  WIDTH  contents of register read_reg_b.

Behaviour:
- Reset:
  - Asynchronous, active-high: all 32 registers go to 0 immediately on reset assertion, independent of clock.
  - While reset is high, read_data_a and read_data_b are 0 for every index.
  - Writes presented while reset is high are discarded.
- Write:
  - On a rising clock edge with write_enable=1 and reset=0, register[write_reg] <= write_data.
  - Exactly one register changes per write.
  - Index decode is a 5-to-32 one-hot decoder gated by write_enable; each register is a WIDTH-bit flop bank with load enable.
- Register 0:
  - Never written. A write with write_reg=0 is ignored.
  - Reads of index 0 always return 0.
- Read:
  - Combinational, zero-cycle latency.
  - read_data_x = register[read_reg_x] via a mux_32 instance per port.
  - Both ports are fully independent and may address the same register.
- Write-then-read timing (feature disabled):
  - A read of the index being written in the same cycle returns the old value until the rising edge.
  - From the edge onward it returns the new value.
- Reset mid-operation: reset asserted in the same cycle as a write drops the write; the register reads 0 after reset.
- Simultaneous writes are impossible: single write port.
- Unknown/X on write_reg with write_enable=0 must not corrupt state.
- No handshake: writes are accepted every cycle unconditionally.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined:
  - If write_enable=1, write_reg != 0, reset=0, and read_reg_x == write_reg, then read_data_x returns write_data combinationally in the same cycle.
  - This lets a writeback-stage result be consumed by decode without a stall.
  - Bypass applies independently to each port.
  - Index 0 never bypasses.
- Undefined: no bypass path; timing as described under Behaviour.
- Both builds must have identical register state after every edge; only read-port timing differs.

Test Plan:
- Reset:
  - Stimulus: assert reset asynchronously mid-cycle after loading r5=0xDEADBEEF.
  - Response: read_reg_a=5 returns 0 immediately, before the next clock edge.
- Basic write/read:
  - Stimulus: write r7=0x12345678, then r31=0xFFFFFFFF; read_reg_a=7, read_reg_b=31.
  - Response: 0x12345678 and 0xFFFFFFFF; all other indices still 0.
- Zero register:
  - Stimulus: write r0=0xAAAAAAAA.
  - Response: read of index 0 on both ports returns 0x00000000 in the following cycles.
- Same-cycle read of write target:
  - Stimulus: r3 holds 0x11; in one cycle write r3=0x22 with read_reg_a=3.
  - Response without macro: 0x11 before the edge, 0x22 after.
  - Response with REGFILE_WRITE_BYPASS_EN: 0x22 in that same cycle.
- Write disable and dual-port read:
  - Stimulus: write_enable=0 with write_reg=9, write_data=0x55; both ports read index 9.
  - Response: both return the prior value, 0.
- Reset racing a write:
  - Stimulus: assert reset in the same cycle as write r12=0x77, release next cycle.
  - Response: r12 reads 0.
